burst_decoder: RTL and testbench



---
 rtl/burst_pkg.sv | 24 ++
 rtl/line_sync.sv | 28 ++
 rtl/burst_decoder.sv | 141 ++++++++++++++
 tb/tb_burst_decoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_pkg.sv
// Shared timing constants and FSM encoding for the gated-carrier link.
// Transmitter and receiver both derive their defaults from here.
package burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int CARRIER_PERIOD    = 1316;
    localparam int BURST_ON_PERIODS  = 21;
    localparam int BURST_OFF_PERIODS = 63;

    // Two silent carrier periods end a burst; two full symbol slots end a frame.
    localparam int DEF_CARRIER_TIMEOUT = 2 * CARRIER_PERIOD;
    localparam int DEF_FRAME_GAP =
        2 * (BURST_ON_PERIODS + BURST_OFF_PERIODS) * CARRIER_PERIOD;

    localparam int DEF_CNT_W      = 18;
    localparam int DEF_MIN_PULSES = 4;
    localparam int DEF_BIT_THRESH = 16;

endpackage

// File: rtl/line_sync.sv
// Two-flop synchroniser for the asynchronous line plus rising-edge detect.
// The edge is seen by the consumer on the third clock after the transition.
module line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= d_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rise = r_sync & ~r_prev;

endmodule

// File: rtl/burst_decoder.sv
// Counts carrier pulses per burst, classifies bursts as 0/1/glitch and
// assembles LSB-first bytes for a valid/ready consumer.
module burst_decoder
    import burst_pkg::*;
#(
    parameter int CNT_W           = DEF_CNT_W,
    parameter int CARRIER_TIMEOUT = DEF_CARRIER_TIMEOUT,
    parameter int MIN_PULSES      = DEF_MIN_PULSES,
    parameter int BIT_THRESH      = DEF_BIT_THRESH,
    parameter int FRAME_GAP       = DEF_FRAME_GAP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LP_TO = CNT_W'(CARRIER_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_FG = CNT_W'(FRAME_GAP - 1);
    localparam logic [7:0]       LP_MIN = 8'(MIN_PULSES);
    localparam logic [7:0]       LP_THR = 8'(BIT_THRESH);

    state_t           r_state;
    logic [7:0]       r_pulse;
    logic [CNT_W-1:0] r_gap;
    logic [2:0]       r_bitcnt;
    logic [7:0]       r_shift;
    logic             r_byte_done;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             r_frame_err;
    logic             r_busy;

    logic             w_rise;
    logic [CNT_W-1:0] w_gap_inc;
    logic [7:0]       w_pulse_inc;
    logic             w_bit;

    line_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (rx_in),
        .rise  (w_rise)
    );

    assign w_gap_inc   = (&r_gap) ? r_gap : r_gap + 1'b1;
    assign w_pulse_inc = (&r_pulse) ? r_pulse : r_pulse + 1'b1;
    assign w_bit       = (r_pulse >= LP_THR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pulse     <= '0;
            r_gap       <= '0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_byte_done <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_byte_done <= 1'b0;

            // An accept in the load cycle frees the slot for the new byte.
            if (r_byte_done) begin
                if (r_valid && !data_ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end

            unique case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= BURST;
                        r_pulse <= 8'd1;
                        r_gap   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                BURST: begin
                    if (w_rise) begin
                        r_pulse <= w_pulse_inc;
                        r_gap   <= '0;
                    end else if (r_gap == LP_TO) begin
                        r_state <= GAP;
                        r_gap   <= w_gap_inc;
                        if (r_pulse >= LP_MIN) begin
                            r_shift     <= {w_bit, r_shift[7:1]};
                            r_bitcnt    <= r_bitcnt + 3'd1;
                            r_byte_done <= (r_bitcnt == 3'd7);
                        end
                    end else begin
                        r_gap <= w_gap_inc;
                    end
                end
                GAP: begin
                    if (w_rise) begin
                        r_state <= BURST;
                        r_pulse <= 8'd1;
                        r_gap   <= '0;
                    end else if (r_gap == LP_FG) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        if (r_bitcnt != 3'd0) begin
                            r_frame_err <= 1'b1;
                            r_bitcnt    <= '0;
                            r_shift     <= '0;
                        end
                    end else begin
                        r_gap <= w_gap_inc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_burst_decoder.sv
// Directed/randomised bench for burst_decoder with a symbol-level
// reference model (pulse counts -> bits -> bytes).
module tb_burst_decoder;

    localparam int CT  = 8;
    localparam int MIN = 4;
    localparam int THR = 16;
    localparam int FG  = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b1;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    burst_decoder #(
        .CNT_W           (18),
        .CARRIER_TIMEOUT (CT),
        .MIN_PULSES      (MIN),
        .BIT_THRESH      (THR),
        .FRAME_GAP       (FG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int fe_cyc = 0;
    int fe_cnt = 0;
    int dv_cycles = 0;
    logic [7:0] got_q[$];

    // Reference model state
    logic [7:0] exp_q[$];
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_hold = 8'h00;
    int         m_nbits = 0;
    bit         m_pending = 0;
    bit         m_ovr = 0;
    int         exp_fe = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid && data_ready) got_q.push_back(data_out);
            if (data_valid) dv_cycles++;
            if (frame_err) begin
                fe_cnt++;
                fe_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_bit(input int n);
        if (n < MIN) return;
        if (n >= THR) m_byte[m_nbits] = 1'b1;
        m_nbits++;
        if (m_nbits == 8) begin
            if (!data_ready) begin
                if (m_pending) m_ovr = 1;
                else begin
                    m_pending = 1;
                    m_hold = m_byte;
                end
            end else begin
                exp_q.push_back(m_byte);
            end
            m_nbits = 0;
            m_byte = 8'h00;
        end
    endtask

    task automatic model_reset();
        m_byte = 8'h00;
        m_nbits = 0;
        m_pending = 0;
        m_ovr = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic pulses(input int n);
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            rx_in = 1'b1;
            rise_cyc = cyc;
            repeat (2) @(posedge clk);
            #1 rx_in = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int c);
        rx_in = 1'b0;
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic send_burst(input int n);
        pulses(n);
        idle(26);
        model_bit(n);
    endtask

    function automatic int rand_cnt(input bit b);
        return b ? int'($urandom_range(40, THR)) : int'($urandom_range(THR - 1, MIN));
    endfunction

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_burst(rand_cnt(b[i]));
    endtask

    task automatic check_q(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_byte"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rx_in = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
    endtask

    initial begin
        int s1[8] = '{20, 8, 20, 20, 8, 8, 8, 20};
        int bnd[8] = '{4, 16, 15, 16, 4, 15, 16, 4};
        logic [7:0] aa;
        int fe0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_flags", {data_valid, overrun, frame_err, busy}, 4'b0000);
        rst_n = 1'b1;
        idle(4);

        // 1: basic byte with the listed pulse counts
        dv_cycles = 0;
        for (int i = 0; i < 8; i++) send_burst(s1[i]);
        idle(10);
        check_q("s1");
        chk("s1_dv_cycles", dv_cycles, 1);
        chk("s1_overrun", overrun, 0);
        chk("s1_fe", fe_cnt, 0);
        idle(80);

        // 2: glitches, threshold boundaries, pulse-count saturation
        for (int i = 0; i < 8; i++) begin
            if (i == 3) send_burst(2);
            send_burst(rand_cnt(i[0] ^ i[2] ? 1'b0 : 1'b1));
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 5) send_burst(3);
            send_burst(bnd[i]);
        end
        send_burst(260);
        for (int i = 0; i < 7; i++) send_burst(rand_cnt(1'($urandom)));
        idle(10);
        check_q("s2");
        idle(80);

        // 3: consumer stalled across two bytes
        data_ready = 1'b0;
        send_byte(8'h3C);
        send_byte(8'hFF);
        idle(10);
        chk("s3_data_out", data_out, m_hold);
        chk("s3_valid", data_valid, m_pending);
        chk("s3_overrun", overrun, m_ovr);
        data_ready = 1'b1;
        exp_q.push_back(m_hold);
        m_pending = 0;
        idle(3);
        check_q("s3");
        chk("s3_overrun_sticky", overrun, m_ovr);
        idle(80);
        do_reset();
        chk("s3_overrun_cleared", overrun, 0);

        // 4: partial byte aborted by frame gap
        fe_cnt = 0;
        for (int i = 0; i < 3; i++) send_burst(rand_cnt(1'($urandom)));
        if (m_nbits != 0) exp_fe++;
        m_nbits = 0;
        m_byte = 8'h00;
        idle(80);
        chk("s4_fe_count", fe_cnt, exp_fe);
        chk("s4_fe_time", fe_cyc - rise_cyc, FG + 3);
        chk("s4_busy", busy, 0);
        send_byte(8'h81);
        idle(10);
        check_q("s4");
        chk("s4_fe_after", fe_cnt, exp_fe);
        idle(80);

        // 5: accept lands in the same cycle the next byte loads
        data_ready = 1'b0;
        send_byte(8'h55);
        for (int i = 0; i < 7; i++) send_burst(rand_cnt(aa_bit(i)));
        pulses(rand_cnt(1'b1));
        aa = m_byte | 8'h80;
        repeat (7) @(posedge clk);
        #1 data_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("s5_data_out", data_out, aa);
        chk("s5_valid", data_valid, 1);
        chk("s5_overrun", overrun, 0);
        exp_q.push_back(m_hold);
        exp_q.push_back(aa);
        m_pending = 0;
        m_nbits = 0;
        m_byte = 8'h00;
        idle(30);
        check_q("s5");
        idle(80);

        // 6: asynchronous reset mid-burst, partial byte discarded
        fe0 = fe_cnt;
        for (int i = 0; i < 3; i++) send_burst(rand_cnt(1'($urandom)));
        pulses(10);
        chk("s6_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_data_out", data_out, 8'h00);
        chk("s6_rst_flags", {data_valid, overrun, frame_err, busy}, 4'b0000);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);
        send_byte(8'h01);
        idle(80);
        check_q("s6");
        chk("s6_no_fe", fe_cnt, fe0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

    function automatic bit aa_bit(input int i);
        logic [7:0] v;
        v = 8'hAA;
        return v[i];
    endfunction

endmodule
